ccff_chain_programmer: RTL

- Drives the configuration-chain (ccff) shift path of routing tiles such as switch and connection blocks, which chain `ccff_head` -> `ccff_tail` through their mux memories.
- Accepts the bitstream as parallel words over a valid/ready handshake, serialises it onto `ccff_head`, and issues a per-cycle shift enable used to gate the chain's `prog_clk`.
- An optional verify mode shifts the stream a second time and compares the bits returned on `ccff_tail`, leaving the chain correctly programmed.

---
 rtl/ccff_chain_programmer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_programmer.sv
// ---------------------------------------------------------------------------
// ccff_chain_programmer
//
// Purpose:
//   Programs the configuration flip-flop (ccff) chain of routing tiles.
//   Parallel bitstream words come in over a valid/ready handshake. Each word
//   is serialised LSB-first onto ccff_head. ccff_shift_en gates the chain's
//   prog_clk for every cycle in which a bit is presented.
//
//   In verify mode the source replays the identical stream a second time.
//   While the replay is shifted in, the bits coming back out of ccff_tail are
//   the first-pass bits, delayed by exactly CHAIN_LEN shifts. Each one is
//   compared with the bit being driven in the same cycle. The first
//   disagreement is recorded in mismatch / mismatch_idx. Once both passes
//   complete, the chain holds the correct stream.
//
// Handshake:
//   A word is transferred on a prog_clk rising edge where word_valid and
//   word_ready are both high. word_ready is high only in LOAD, and it does not
//   depend on word_valid. A word_valid that is offered while word_ready is low
//   is left pending and is not consumed.
//
// Ports:
//   prog_clk       in   sole clock; every state update is on its rising edge
//   pReset         in   synchronous, active-high reset
//   start          in   begin programming; honoured only in IDLE
//   verify         in   captured together with start; 1 = two-pass program
//                       followed by a readback check
//   abort          in   return to IDLE on the next edge from any busy state
//   word_in        in   bitstream word; bit 0 is shifted first
//   word_valid     in   word_in is valid
//   word_ready     out  a word is accepted this cycle if word_valid is high
//   ccff_head      out  serial data into the chain
//   ccff_shift_en  out  chain advances on the edge that ends this cycle
//   ccff_tail      in   serial data from the end of the chain
//   busy           out  programmer is not idle
//   done           out  one-cycle completion pulse
//   mismatch       out  sticky readback error; cleared by an accepted start
//   mismatch_idx   out  bit index of the first readback error
//   state_dbg      out  current FSM state, for observation only
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ccff_chain_programmer #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 36,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_idx,
    output logic [1:0]        state_dbg
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] WORD_BITS_MAX = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CHAIN_BITS    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              verify_q;     // verify mode latched with start
    logic              pass_q;       // 0 = first pass, 1 = replay/compare pass
    logic [WORD_W-1:0] shreg_q;      // word being serialised, LSB is next bit
    logic [CNT_W-1:0]  bit_cnt_q;    // chain bit index within the current pass
    logic [CNT_W-1:0]  word_bits_q;  // bits of the current word still to shift
    logic              mismatch_q;
    logic [CNT_W-1:0]  mismatch_idx_q;

    // -----------------------------------------------------------------------
    // Decodes used by both the next-state logic and the datapath
    // -----------------------------------------------------------------------
    logic              in_idle;
    logic              in_load;
    logic              in_shift;
    logic              abort_hit;
    logic              load_take;
    logic              last_bit;
    logic              word_last;
    logic              replay_next;
    logic [CNT_W-1:0]  bits_left;
    logic [CNT_W-1:0]  load_bits;
    logic              tail_bad;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_load   = (state_q == ST_LOAD);
    assign in_shift  = (state_q == ST_SHIFT);

    // Abort takes effect from any busy state and wins over all other activity.
    assign abort_hit = abort && !in_idle;

    assign load_take = in_load && word_valid && !abort_hit;

    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign word_last = (word_bits_q == ONE);

    // The end of the first pass in verify mode returns to LOAD to fetch the
    // replayed stream instead of finishing.
    assign replay_next = verify_q && !pass_q;

    // The final word can be wider than the remaining chain. Its high bits are
    // never shifted out; the early return to LOAD or DONE discards them.
    assign bits_left = CHAIN_BITS - bit_cnt_q;
    assign load_bits = (bits_left < WORD_BITS_MAX) ? bits_left : WORD_BITS_MAX;

    // During the replay pass, the tail carries the first-pass copy of the same
    // bit index that is being driven into the head.
    assign tail_bad = in_shift && pass_q && (ccff_tail != shreg_q[0]);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = replay_next ? ST_LOAD : ST_DONE;
                end else if (word_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q        <= ST_IDLE;
            verify_q       <= 1'b0;
            pass_q         <= 1'b0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            word_bits_q    <= '0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
        end else begin
            state_q <= state_d;

            // Accepted start: fresh run, error status cleared.
            if (in_idle && start) begin
                verify_q       <= verify;
                pass_q         <= 1'b0;
                bit_cnt_q      <= '0;
                mismatch_q     <= 1'b0;
                mismatch_idx_q <= '0;
            end

            if (load_take) begin
                shreg_q     <= word_in;
                word_bits_q <= load_bits;
            end

            if (in_shift && !abort_hit) begin
                shreg_q     <= shreg_q >> 1;
                word_bits_q <= word_bits_q - ONE;

                if (last_bit && replay_next) begin
                    pass_q    <= 1'b1;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + ONE;
                end

                // Only the first disagreement is recorded.
                if (tail_bad && !mismatch_q) begin
                    mismatch_q     <= 1'b1;
                    mismatch_idx_q <= bit_cnt_q;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registers only, never from inputs
    // -----------------------------------------------------------------------
    assign word_ready    = in_load;
    assign ccff_shift_en = in_shift;
    assign ccff_head     = in_shift && shreg_q[0];
    assign busy          = !in_idle;
    assign done          = (state_q == ST_DONE);
    assign mismatch      = mismatch_q;
    assign mismatch_idx  = mismatch_idx_q;
    assign state_dbg     = state_q;

endmodule
